// File: rtl/shader_issue_ctrl.sv
// Opcode encoding plus the in-order single-issue sequencer that sits behind
// fetch/decode and owns the shared ALU/MUL/DIV unit and the memory port.

package opcode_pkg;
  typedef enum logic [5:0] {
    OP_NOP   = 6'd0,
    OP_ADD   = 6'd1,
    OP_SUB   = 6'd2,
    OP_MUL   = 6'd3,
    OP_DIV   = 6'd4,
    OP_LOAD  = 6'd10,
    OP_STORE = 6'd11,
    OP_MAX   = 6'd63
  } opcodes;
endpackage

module shader_issue_ctrl
  import opcode_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8,
  parameter int MEM_TO  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [5:0]  instr_opcode,
  input  logic [3:0]  instr_rd,
  input  logic [3:0]  instr_rs1,
  input  logic [3:0]  instr_rs2,
  output logic        instr_ready,
  output logic [5:0]  ex_op,
  output logic [3:0]  ex_rs1,
  output logic [3:0]  ex_rs2,
  output logic        ex_start,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic        busy,
  output logic        illegal_op,
  output logic        mem_err,
  output logic [15:0] retire_cnt
);

  localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int LAT_W   = $clog2(LAT_MAX + 1);
  localparam int TO_W    = $clog2(MEM_TO + 1);

  localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(MEM_TO - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MEM  = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t            state_q;
  logic [5:0]        ex_op_q;
  logic [3:0]        ex_rs1_q;
  logic [3:0]        ex_rs2_q;
  logic [3:0]        rf_waddr_q;
  logic              ex_start_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic              rf_we_q;
  logic              illegal_op_q;
  logic              mem_err_q;
  logic              timed_out_q;
  logic [15:0]       retire_cnt_q;
  logic [LAT_W-1:0]  lat_cnt_q;
  logic [TO_W-1:0]   to_cnt_q;

  function automatic logic is_alu(input logic [5:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_mem(input logic [5:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return is_alu(op) || is_mem(op) || (op == OP_NOP);
  endfunction

  // Cycles spent in EXEC: ADD/SUB take one, MUL/DIV their configured latency.
  function automatic logic [LAT_W-1:0] exec_lat(input logic [5:0] op);
    logic [LAT_W-1:0] lat;
    lat = LAT_ONE;
    if (op == OP_MUL) lat = LAT_W'(MUL_LAT);
    if (op == OP_DIV) lat = LAT_W'(DIV_LAT);
    return lat;
  endfunction

  // Sequencer: state, latched instruction fields, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ex_op_q      <= '0;
      ex_rs1_q     <= '0;
      ex_rs2_q     <= '0;
      rf_waddr_q   <= '0;
      ex_start_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      rf_we_q      <= 1'b0;
      illegal_op_q <= 1'b0;
      mem_err_q    <= 1'b0;
      timed_out_q  <= 1'b0;
      retire_cnt_q <= '0;
      lat_cnt_q    <= '0;
      to_cnt_q     <= '0;
    end else begin
      // Pulses default low; only the transitions below raise them.
      ex_start_q <= 1'b0;
      rf_we_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            ex_op_q    <= instr_opcode;
            ex_rs1_q   <= instr_rs1;
            ex_rs2_q   <= instr_rs2;
            rf_waddr_q <= instr_rd;
            if (is_alu(instr_opcode)) begin
              state_q    <= S_EXEC;
              ex_start_q <= 1'b1;
              lat_cnt_q  <= exec_lat(instr_opcode);
            end else if (is_mem(instr_opcode)) begin
              state_q   <= S_MEM;
              mem_req_q <= 1'b1;
              mem_we_q  <= (instr_opcode == OP_STORE);
              to_cnt_q  <= '0;
            end else begin
              state_q <= S_WB;
            end
          end
        end
        S_EXEC: begin
          if (lat_cnt_q == LAT_ONE) begin
            state_q <= S_WB;
            rf_we_q <= 1'b1;
          end else begin
            lat_cnt_q <= lat_cnt_q - LAT_ONE;
          end
        end
        S_MEM: begin
          // Ack is checked first so an ack in the last allowed cycle still succeeds.
          if (mem_ack) begin
            state_q   <= S_WB;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            rf_we_q   <= (ex_op_q == OP_LOAD);
          end else if (to_cnt_q == TO_LAST) begin
            state_q     <= S_WB;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            timed_out_q <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        S_WB: begin
          state_q      <= S_IDLE;
          retire_cnt_q <= retire_cnt_q + 16'd1;
          timed_out_q  <= 1'b0;
          if (!is_legal(ex_op_q)) illegal_op_q <= 1'b1;
          if (timed_out_q)        mem_err_q    <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign instr_ready = rst_n && (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign ex_op       = ex_op_q;
  assign ex_rs1      = ex_rs1_q;
  assign ex_rs2      = ex_rs2_q;
  assign ex_start    = ex_start_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign illegal_op  = illegal_op_q;
  assign mem_err     = mem_err_q;
  assign retire_cnt  = retire_cnt_q;

endmodule

// File: tb/tb_shader_issue_ctrl.sv
// Directed bench for shader_issue_ctrl: ALU timing, back-to-back issue,
// memory ack/timeout, illegal opcodes and reset in the middle of an operation.

module tb_shader_issue_ctrl;
  import opcode_pkg::*;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 8;
  localparam int MEM_TO  = 4;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [5:0]  instr_opcode;
  logic [3:0]  instr_rd;
  logic [3:0]  instr_rs1;
  logic [3:0]  instr_rs2;
  logic        instr_ready;
  logic [5:0]  ex_op;
  logic [3:0]  ex_rs1;
  logic [3:0]  ex_rs2;
  logic        ex_start;
  logic        mem_req;
  logic        mem_we;
  logic        mem_ack;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic        busy;
  logic        illegal_op;
  logic        mem_err;
  logic [15:0] retire_cnt;

  int n_checks = 0;
  int n_errors = 0;

  shader_issue_ctrl #(
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT),
    .MEM_TO (MEM_TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_opcode(instr_opcode),
    .instr_rd    (instr_rd),
    .instr_rs1   (instr_rs1),
    .instr_rs2   (instr_rs2),
    .instr_ready (instr_ready),
    .ex_op       (ex_op),
    .ex_rs1      (ex_rs1),
    .ex_rs2      (ex_rs2),
    .ex_start    (ex_start),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_ack     (mem_ack),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .busy        (busy),
    .illegal_op  (illegal_op),
    .mem_err     (mem_err),
    .retire_cnt  (retire_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_all_zero(input string pre);
    chk({pre, "_ex_op"},      32'(ex_op),      32'(OP_NOP));
    chk({pre, "_ex_rs1"},     32'(ex_rs1),     0);
    chk({pre, "_ex_rs2"},     32'(ex_rs2),     0);
    chk({pre, "_ex_start"},   32'(ex_start),   0);
    chk({pre, "_mem_req"},    32'(mem_req),    0);
    chk({pre, "_mem_we"},     32'(mem_we),     0);
    chk({pre, "_rf_we"},      32'(rf_we),      0);
    chk({pre, "_rf_waddr"},   32'(rf_waddr),   0);
    chk({pre, "_busy"},       32'(busy),       0);
    chk({pre, "_illegal_op"}, 32'(illegal_op), 0);
    chk({pre, "_mem_err"},    32'(mem_err),    0);
    chk({pre, "_retire_cnt"}, 32'(retire_cnt), 0);
  endtask

  task automatic apply_reset();
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    mem_ack     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Present one instruction for exactly one edge; DUT must already be idle.
  task automatic issue(input logic [5:0] op, input logic [3:0] rd,
                       input logic [3:0] rs1, input logic [3:0] rs2);
    instr_valid  = 1'b1;
    instr_opcode = op;
    instr_rd     = rd;
    instr_rs1    = rs1;
    instr_rs2    = rs2;
    tick();
    instr_valid = 1'b0;
  endtask

  int          n_start;
  int          n_we;
  int          n_req;
  int          n_mwe;
  logic [5:0]  ill_ops [2];

  initial begin
    rst_n        = 1'b0;
    instr_valid  = 1'b0;
    instr_opcode = '0;
    instr_rd     = '0;
    instr_rs1    = '0;
    instr_rs2    = '0;
    mem_ack      = 1'b0;
    ill_ops[0]   = 6'd5;
    ill_ops[1]   = 6'd63;

    // Reset state
    tick();
    tick();
    chk("rst_ready", 32'(instr_ready), 0);
    check_all_zero("rst");
    rst_n = 1'b1;
    tick();
    chk("idle_ready", 32'(instr_ready), 1);
    chk("idle_busy",  32'(busy),        0);

    // ADD: start at T+1, writeback at T+2, ready at T+3
    issue(OP_ADD, 4'd5, 4'd1, 4'd2);
    chk("add_start",   32'(ex_start),    1);
    chk("add_busy",    32'(busy),        1);
    chk("add_ready",   32'(instr_ready), 0);
    chk("add_ex_op",   32'(ex_op),       32'(OP_ADD));
    chk("add_rs1",     32'(ex_rs1),      1);
    chk("add_rs2",     32'(ex_rs2),      2);
    chk("add_we_early",32'(rf_we),       0);
    tick();
    chk("add_we",      32'(rf_we),       1);
    chk("add_waddr",   32'(rf_waddr),    5);
    chk("add_start_1p",32'(ex_start),    0);
    tick();
    chk("add_ready_again", 32'(instr_ready), 1);
    chk("add_retire",      32'(retire_cnt),  1);
    chk("add_we_off",      32'(rf_we),       0);
    chk("add_idle",        32'(busy),        0);

    // MUL then DIV with instr_valid held high
    apply_reset();
    instr_valid  = 1'b1;
    instr_opcode = OP_MUL;
    instr_rd     = 4'd3;
    instr_rs1    = 4'd1;
    instr_rs2    = 4'd2;
    tick();
    instr_opcode = OP_DIV;
    instr_rd     = 4'd4;
    instr_rs1    = 4'd6;
    instr_rs2    = 4'd7;
    n_start = 0;
    n_we    = 0;
    for (int k = 1; k <= 15; k++) begin
      if (ex_start) n_start++;
      if (rf_we) begin
        n_we++;
        chk("muldiv_we_cycle", 32'(k), (n_we == 1) ? 32'd4 : 32'd14);
        chk("muldiv_waddr", 32'(rf_waddr), (n_we == 1) ? 32'd3 : 32'd4);
      end
      if (k == 5) chk("div_accept_ready", 32'(instr_ready), 1);
      if (k == 6) chk("div_start", 32'(ex_start), 1);
      tick();
      if (k == 5) instr_valid = 1'b0;
    end
    chk("muldiv_starts", 32'(n_start), 2);
    chk("muldiv_wes",    32'(n_we),    2);
    chk("muldiv_retire", 32'(retire_cnt), 2);
    chk("muldiv_ex_op",  32'(ex_op),   32'(OP_DIV));

    // LOAD with ack in the 4th MEM cycle, which is also the timeout cycle
    issue(OP_LOAD, 4'd7, 4'd3, 4'd4);
    n_req = 0;
    n_mwe = 0;
    n_we  = 0;
    for (int k = 1; k <= 6; k++) begin
      if (mem_req) n_req++;
      if (mem_we) n_mwe++;
      if (rf_we) begin
        n_we++;
        chk("ld_we_cycle", 32'(k), 5);
        chk("ld_waddr",    32'(rf_waddr), 7);
      end
      mem_ack = (k == 4);
      tick();
    end
    mem_ack = 1'b0;
    chk("ld_req_cycles", 32'(n_req), 4);
    chk("ld_mem_we",     32'(n_mwe), 0);
    chk("ld_we_count",   32'(n_we),  1);
    chk("ld_no_err",     32'(mem_err), 0);
    chk("ld_retire",     32'(retire_cnt), 3);

    // STORE with immediate ack
    issue(OP_STORE, 4'd9, 4'd1, 4'd2);
    chk("st_req", 32'(mem_req), 1);
    chk("st_we",  32'(mem_we),  1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("st_rf_we",   32'(rf_we),   0);
    chk("st_req_off", 32'(mem_req), 0);
    chk("st_wb_busy", 32'(busy),    1);
    tick();
    chk("st_ready",  32'(instr_ready), 1);
    chk("st_retire", 32'(retire_cnt),  4);

    // LOAD with no ack: timeout after MEM_TO cycles
    issue(OP_LOAD, 4'd8, 4'd1, 4'd1);
    n_req = 0;
    n_we  = 0;
    for (int k = 1; k <= 5; k++) begin
      if (mem_req) n_req++;
      if (rf_we) n_we++;
      if (k == 5) begin
        chk("to_wb_busy",   32'(busy),    1);
        chk("to_err_in_wb", 32'(mem_err), 0);
      end
      tick();
    end
    chk("to_req_cycles", 32'(n_req), MEM_TO);
    chk("to_rf_we",      32'(n_we),  0);
    chk("to_mem_err",    32'(mem_err), 1);
    chk("to_retire",     32'(retire_cnt), 5);
    chk("to_ready",      32'(instr_ready), 1);

    // NOP: retires in two cycles, not illegal, mem_err stays set
    issue(OP_NOP, 4'd1, 4'd0, 4'd0);
    chk("nop_busy",  32'(busy),     1);
    chk("nop_start", 32'(ex_start), 0);
    chk("nop_req",   32'(mem_req),  0);
    chk("nop_we",    32'(rf_we),    0);
    tick();
    chk("nop_ready",      32'(instr_ready), 1);
    chk("nop_retire",     32'(retire_cnt),  6);
    chk("nop_not_ill",    32'(illegal_op),  0);
    chk("mem_err_sticky", 32'(mem_err),     1);

    // Illegal opcodes 5 and 63
    for (int i = 0; i < 2; i++) begin
      issue(ill_ops[i], 4'd2, 4'd0, 4'd0);
      chk("ill_start", 32'(ex_start), 0);
      chk("ill_req",   32'(mem_req),  0);
      chk("ill_we",    32'(rf_we),    0);
      chk("ill_busy",  32'(busy),     1);
      tick();
      chk("ill_ready",  32'(instr_ready), 1);
      chk("ill_flag",   32'(illegal_op),  1);
      chk("ill_retire", 32'(retire_cnt),  32'(7 + i));
    end

    // Reset during DIV EXEC cycle 4
    apply_reset();
    chk("rst_clears_err", 32'(mem_err),    0);
    chk("rst_clears_ill", 32'(illegal_op), 0);
    issue(OP_DIV, 4'd6, 4'd1, 4'd2);
    tick();
    tick();
    tick();
    chk("div4_busy", 32'(busy), 1);
    rst_n = 1'b0;
    tick();
    check_all_zero("rdiv");
    chk("rdiv_ready", 32'(instr_ready), 0);
    rst_n = 1'b1;
    n_we = 0;
    for (int k = 0; k < 10; k++) begin
      if (rf_we) n_we++;
      tick();
    end
    chk("rdiv_no_we",  32'(n_we),       0);
    chk("rdiv_retire", 32'(retire_cnt), 0);
    chk("rdiv_idle",   32'(busy),       0);

    // Reset during MEM, then a late ack while idle
    issue(OP_LOAD, 4'd7, 4'd1, 4'd2);
    chk("rmem_req", 32'(mem_req), 1);
    tick();
    rst_n   = 1'b0;
    mem_ack = 1'b1;
    tick();
    check_all_zero("rmem");
    rst_n = 1'b1;
    tick();
    chk("late_ack_we",   32'(rf_we),   0);
    chk("late_ack_busy", 32'(busy),    0);
    chk("late_ack_req",  32'(mem_req), 0);
    mem_ack = 1'b0;
    tick();
    chk("late_ack_retire", 32'(retire_cnt), 0);
    chk("late_ack_err",    32'(mem_err),    0);
    chk("late_ack_ready",  32'(instr_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/shader_issue_ctrl.md
# shader_issue_ctrl

In-order, single-issue sequencer between the instruction source and the shader execution/memory resources. It accepts one decoded instruction at a time, using `opcode_pkg::opcodes` encoding. It then either:
- times the shared ALU/MUL/DIV unit with per-class latency counters, or
- runs a request/acknowledge transaction with the memory port.

On completion it drives register-file writeback and retires the instruction. It sits directly after fetch/decode and owns the execution unit and the memory port exclusively.

## Interface
- `MUL_LAT`, 3, OP_MUL execution cycles (≥1)
- `DIV_LAT`, 8, OP_DIV execution cycles (≥1)
- `MEM_TO`, 64, max cycles `mem_req` is held without `mem_ack` (≥1)

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `instr_valid` in 1: instruction offered
- `instr_opcode` in 6: opcode (`opcode_pkg` encoding)
- `instr_rd` in 4: destination register
- `instr_rs1` in 4: source register 1
- `instr_rs2` in 4: source register 2
- `instr_ready` out 1: controller can accept
- `ex_op` out 6: latched opcode presented to the execution unit and the memory unit
- `ex_rs1` out 4: latched source register 1
- `ex_rs2` out 4: latched source register 2
- `ex_start` out 1: one-cycle start pulse for ALU/MUL/DIV
- `mem_req` out 1: memory request, level
- `mem_we` out 1: 1 = store, 0 = load; valid while `mem_req`=1
- `mem_ack` in 1: memory completion
- `rf_we` out 1: register-file write enable, one-cycle pulse
- `rf_waddr` out 4: writeback address
- `busy` out 1: state ≠ IDLE
- `illegal_op` out 1: sticky, unknown opcode seen
- `mem_err` out 1: sticky, memory timeout
- `retire_cnt` out 16: retired-instruction count, wraps

## Operation
- **States:** IDLE, EXEC, MEM, WB.
- **IDLE**
  - `instr_ready`=1; it is 0 while `rst_n`=0 and in all other states.
  - On `instr_valid && instr_ready`, latch opcode/rd/rs1/rs2 into `ex_op`/`rf_waddr`/`ex_rs1`/`ex_rs2`.
  - Next state by opcode:
    - OP_ADD, OP_SUB, OP_MUL, OP_DIV → EXEC
    - OP_LOAD, OP_STORE → MEM
    - OP_NOP and all other codes (including OP_MAX, 5–9, 12–62) → WB
- **EXEC**
  - Entry cycle: `ex_start`=1 and latency counter loads with 1 (ADD/SUB), `MUL_LAT`, or `DIV_LAT`.
  - Counter decrements each cycle; state stays EXEC for exactly that many cycles, then → WB.
- **MEM**
  - `mem_req`=1 and `mem_we`=(`ex_op`==OP_STORE) for every MEM cycle.
  - `mem_ack` sampled high → WB; `mem_req` is 0 the following cycle.
  - Timeout counter starts at 0 on entry and increments per cycle without ack. On reaching `MEM_TO` with no ack → WB, set `mem_err`.
  - Ack arriving in the same cycle as the timeout wins: success, no `mem_err`.
- **WB** (one cycle)
  - `rf_we`=1 only for ADD/SUB/MUL/DIV, and for LOAD that completed by ack. STORE, NOP, illegal, and timed-out LOAD give `rf_we`=0.
  - Illegal opcode sets `illegal_op`.
  - `retire_cnt` increments for every instruction, timeouts included; 0xFFFF→0x0000.
  - Next state IDLE.
- `mem_ack` outside MEM is ignored. `instr_valid` outside IDLE is ignored; the source holds it.
- Sticky flags clear only on reset.

## Timing
- **Reset** (`rst_n`=0 at a rising edge): state IDLE. All of the following are 0: `ex_op` (OP_NOP), `ex_rs1`, `ex_rs2`, `ex_start`, `mem_req`, `mem_we`, `rf_we`, `rf_waddr`, `busy`, `illegal_op`, `mem_err`, `retire_cnt`.
- **Reset mid-operation:** abort with no writeback and no retire. `mem_req` drops at that edge; a pending ack is discarded.
- With the accept edge at T, `busy`=1 from T+1.
- **ALU-class:** EXEC T+1..T+L, `rf_we` at T+L+1, `instr_ready` again at T+L+2. ADD latency is therefore 2 cycles to `rf_we`, with one instruction per 3 cycles.
- **NOP/illegal:** WB at T+1, `instr_ready` at T+2.
- **Memory:** `mem_req` rises at T+1. With ack sampled at edge X, WB (and `rf_we` for LOAD) is at X+1.
- **Timeout:** WB at T+1+`MEM_TO`, with `mem_err` visible from the following cycle.

## Test plan
- **ADD:** reset; ADD rd=5, rs1=1, rs2=2 accepted at T → `ex_start` at T+1, `rf_we`=1 with `rf_waddr`=5 at T+2, `retire_cnt`=1, `instr_ready` at T+3.
- **MUL then DIV back-to-back** (`instr_valid` held high): MUL `rf_we` at T+4; DIV accepted at T+5 and writes back at T+14. Check `ex_start` pulses exactly twice and `retire_cnt`=2.
- **LOAD/STORE:** LOAD rd=7 with ack delayed 3 cycles → `mem_req` high for 4 cycles, `mem_we`=0, `rf_we` with `rf_waddr`=7 the cycle after ack. STORE with immediate ack → `mem_we`=1, no `rf_we`.
- **Timeout:** LOAD with `MEM_TO`=4 and no ack → `mem_req` high 4 cycles, then WB with `rf_we`=0. Then `mem_err`=1 sticky and `retire_cnt`+1.
- **Illegal opcode:** opcode 6'd5, then 6'd63 → each retires in 2 cycles, no `ex_start`, `mem_req` or `rf_we`; `illegal_op`=1 stays set.
- **Reset mid-op:** assert `rst_n`=0 during DIV EXEC cycle 4 and during MEM → all outputs 0 next cycle, no `rf_we`, `retire_cnt` unchanged at 0. A late `mem_ack` after reset is ignored.
